// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master, one-slave round-robin arbiter for the 32-bit
// peripheral I/O bus. A grant is held until the slave acks or the granted
// master drops sel. Arbitration takes one IDLE cycle per transfer.
//
// Optional build macro IO_ARB_TIMEOUT_EN: adds a per-grant watchdog that
// terminates a transfer with ack+err after TIMEOUT cycles without slave ack.
//
// state | meaning
// IDLE  | no grant; arbitrate pending requests
// GNT0  | master 0 owns the slave port
// GNT1  | master 1 owns the slave port
module io_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_m0_sel,
  input  logic              io_m0_we,
  input  logic [ADDR_W-1:0] io_m0_addr,
  input  logic [DATA_W-1:0] io_m0_dat2,
  output logic [DATA_W-1:0] io_m0_dat4,
  output logic              io_m0_ack,
  output logic              io_m0_err,
  input  logic              io_m1_sel,
  input  logic              io_m1_we,
  input  logic [ADDR_W-1:0] io_m1_addr,
  input  logic [DATA_W-1:0] io_m1_dat2,
  output logic [DATA_W-1:0] io_m1_dat4,
  output logic              io_m1_ack,
  output logic              io_m1_err,
  output logic              io_bus_sel,
  output logic              io_bus_we,
  output logic [ADDR_W-1:0] io_bus_addr,
  output logic [DATA_W-1:0] io_bus_dat2,
  input  logic [DATA_W-1:0] io_bus_dat4,
  input  logic              io_bus_ack,
  output logic [1:0]        io_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   timeout_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("io_bus_arbiter: TIMEOUT must be at least 1");
  end

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             granted_sel;

  // Watchdog only fires while the granted master still requests; a dropped
  // sel on the terminal cycle is an ordinary abort, and a slave ack wins.
  always_comb begin
    granted_sel = ((state_q == GNT0) && io_m0_sel) || ((state_q == GNT1) && io_m1_sel);
    timeout_hit = granted_sel && !io_bus_ack && (cnt_q == CNT_W'(TIMEOUT));
    cnt_d       = '0;
    if ((state_q != IDLE) && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Grant-cycle counter; cleared whenever a grant is entered or left.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic and combinational bus/master muxing; all outputs are
  // held at zero while reset is asserted, even mid-transfer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    io_bus_sel   = 1'b0;
    io_bus_we    = 1'b0;
    io_bus_addr  = '0;
    io_bus_dat2  = '0;
    io_m0_dat4   = '0;
    io_m0_ack    = 1'b0;
    io_m0_err    = 1'b0;
    io_m1_dat4   = '0;
    io_m1_ack    = 1'b0;
    io_m1_err    = 1'b0;
    io_grant     = 2'b00;
    case (state_q)
      IDLE: begin
        if (io_m0_sel && io_m1_sel) begin
          state_d      = last_grant_q ? GNT0 : GNT1;
          last_grant_d = ~last_grant_q;
        end else if (io_m0_sel) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (io_m1_sel) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0: begin
        io_bus_sel  = io_m0_sel && !timeout_hit;
        io_bus_we   = io_m0_we;
        io_bus_addr = io_m0_addr;
        io_bus_dat2 = io_m0_dat2;
        io_m0_dat4  = io_bus_dat4;
        io_m0_ack   = io_bus_ack || timeout_hit;
        io_m0_err   = timeout_hit;
        io_grant    = 2'b01;
        if (io_bus_ack || !io_m0_sel || timeout_hit) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        io_bus_sel  = io_m1_sel && !timeout_hit;
        io_bus_we   = io_m1_we;
        io_bus_addr = io_m1_addr;
        io_bus_dat2 = io_m1_dat2;
        io_m1_dat4  = io_bus_dat4;
        io_m1_ack   = io_bus_ack || timeout_hit;
        io_m1_err   = timeout_hit;
        io_grant    = 2'b10;
        if (io_bus_ack || !io_m1_sel || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d      = IDLE;
      last_grant_d = 1'b1;
      io_bus_sel   = 1'b0;
      io_bus_we    = 1'b0;
      io_bus_addr  = '0;
      io_bus_dat2  = '0;
      io_m0_dat4   = '0;
      io_m0_ack    = 1'b0;
      io_m0_err    = 1'b0;
      io_m1_dat4   = '0;
      io_m1_ack    = 1'b0;
      io_m1_err    = 1'b0;
      io_grant     = 2'b00;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: scenario tasks with a scoreboard of expected
// (master, read data) pairs that is popped whenever a master sees an ack.
`timescale 1ns/1ps
module tb_io_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;
  localparam logic [31:0] SLV_K = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_m0_sel, io_m0_we, io_m1_sel, io_m1_we;
  logic [AW-1:0] io_m0_addr, io_m1_addr, io_bus_addr;
  logic [DW-1:0] io_m0_dat2, io_m1_dat2, io_m0_dat4, io_m1_dat4;
  logic          io_m0_ack, io_m0_err, io_m1_ack, io_m1_err;
  logic          io_bus_sel, io_bus_we, io_bus_ack;
  logic [DW-1:0] io_bus_dat2, io_bus_dat4;
  logic [1:0]    io_grant;

  logic          slv_ack;
  logic          slv_fixed_en;
  logic [31:0]   slv_fixed;

  typedef struct packed {
    logic        mst;
    logic [31:0] dat4;
  } exp_t;
  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // Slave model: echoes a scrambled address as read data unless a fixed value is forced.
  assign io_bus_ack  = slv_ack;
  assign io_bus_dat4 = slv_fixed_en ? slv_fixed : (io_bus_addr ^ SLV_K);

  wire [135:0] all_out = {io_grant, io_bus_sel, io_bus_we, io_bus_addr, io_bus_dat2,
                          io_m0_ack, io_m1_ack, io_m0_err, io_m1_err, io_m0_dat4, io_m1_dat4};

  io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .io_m0_sel(io_m0_sel), .io_m0_we(io_m0_we), .io_m0_addr(io_m0_addr),
    .io_m0_dat2(io_m0_dat2), .io_m0_dat4(io_m0_dat4), .io_m0_ack(io_m0_ack), .io_m0_err(io_m0_err),
    .io_m1_sel(io_m1_sel), .io_m1_we(io_m1_we), .io_m1_addr(io_m1_addr),
    .io_m1_dat2(io_m1_dat2), .io_m1_dat4(io_m1_dat4), .io_m1_ack(io_m1_ack), .io_m1_err(io_m1_err),
    .io_bus_sel(io_bus_sel), .io_bus_we(io_bus_we), .io_bus_addr(io_bus_addr),
    .io_bus_dat2(io_bus_dat2), .io_bus_dat4(io_bus_dat4), .io_bus_ack(io_bus_ack),
    .io_grant(io_grant)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_m0_sel = 1'b1; io_m0_we = 1'b1; io_m0_addr = 32'h0000_0010; io_m0_dat2 = 32'hAAAA_0000;
    io_m1_sel = 1'b1; io_m1_we = 1'b1; io_m1_addr = 32'h0000_0020; io_m1_dat2 = 32'hBBBB_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++; if (all_out !== '0) $display("FAIL rst_outputs_zero: got %h expected 0", all_out); else n_pass++;
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (io_grant !== 2'b00) $display("FAIL rst_first_idle_grant: got %b expected 00", io_grant); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (io_grant !== 2'b01) $display("FAIL rst_first_tie_m0: got %b expected 01", io_grant); else n_pass++;
    n_total++; if (io_bus_sel !== 1'b1) $display("FAIL rst_first_bus_sel: got %b expected 1", io_bus_sel); else n_pass++;
    next_cycle();
    io_m0_sel = 1'b0; io_m1_sel = 1'b0;
    @(negedge clk);
    n_total++; if (io_bus_sel !== 1'b0 || io_m0_ack !== 1'b0) $display("FAIL rst_drop_sel: got sel=%b ack=%b expected 0 0", io_bus_sel, io_m0_ack); else n_pass++;
    next_cycle();
  endtask

  task automatic test_m0_write();
    exp_t e;
    slv_ack = 1'b1;
    io_m0_sel = 1'b1; io_m0_we = 1'b1; io_m0_addr = 32'h0000_FF00; io_m0_dat2 = 32'h1234_5678;
    sb_q.push_back('{mst: 1'b0, dat4: 32'h0000_FF00 ^ SLV_K});
    @(negedge clk);
    n_total++; if (io_bus_sel !== 1'b0 || io_grant !== 2'b00) $display("FAIL wr_idle_latency: got sel=%b grant=%b expected 0 00", io_bus_sel, io_grant); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (io_bus_sel !== 1'b1 || io_bus_we !== 1'b1) $display("FAIL wr_bus_sel_we: got %b%b expected 11", io_bus_sel, io_bus_we); else n_pass++;
    n_total++; if (io_bus_dat2 !== 32'h1234_5678) $display("FAIL wr_bus_dat2: got %h expected 12345678", io_bus_dat2); else n_pass++;
    n_total++; if (io_bus_addr !== 32'h0000_FF00) $display("FAIL wr_bus_addr: got %h expected 0000ff00", io_bus_addr); else n_pass++;
    n_total++; if (io_m0_ack !== 1'b1 || io_m1_ack !== 1'b0) $display("FAIL wr_acks: got m0=%b m1=%b expected 1 0", io_m0_ack, io_m1_ack); else n_pass++;
    if (io_m0_ack === 1'b1) begin
      n_total++;
      if (sb_q.size() == 0) $display("FAIL wr_sb_empty: got ack expected none");
      else begin
        e = sb_q.pop_front();
        if (e.mst !== 1'b0 || io_m0_dat4 !== e.dat4) $display("FAIL wr_sb: got m0 dat4 %h expected master %0d dat4 %h", io_m0_dat4, e.mst, e.dat4); else n_pass++;
      end
    end
    next_cycle();
    io_m0_sel = 1'b0; io_m0_we = 1'b0;
    @(negedge clk);
    n_total++; if (io_grant !== 2'b00 || io_m0_ack !== 1'b0) $display("FAIL wr_back_idle: got grant=%b ack=%b expected 00 0", io_grant, io_m0_ack); else n_pass++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [8];
    int   acks0, acks1;
    exp_t e;
    logic mst;
    exp_gnt = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    acks0 = 0; acks1 = 0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    slv_ack = 1'b1;
    io_m0_sel = 1'b1; io_m0_we = 1'b0; io_m0_addr = 32'h0000_0100;
    io_m1_sel = 1'b1; io_m1_we = 1'b1; io_m1_addr = 32'h0000_0200; io_m1_dat2 = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{mst: i[0], dat4: (i[0] ? 32'h0000_0200 : 32'h0000_0100) ^ SLV_K});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_total++; if (io_grant !== exp_gnt[c]) $display("FAIL rr_grant_c%0d: got %b expected %b", c, io_grant, exp_gnt[c]); else n_pass++;
      if (io_m0_ack === 1'b1 || io_m1_ack === 1'b1) begin
        mst = io_m1_ack;
        if (io_m0_ack === 1'b1) acks0++;
        if (io_m1_ack === 1'b1) acks1++;
        n_total++;
        if (sb_q.size() == 0) $display("FAIL rr_sb_empty: got ack expected none");
        else begin
          e = sb_q.pop_front();
          if (e.mst !== mst || (mst ? io_m1_dat4 : io_m0_dat4) !== e.dat4)
            $display("FAIL rr_sb_c%0d: got master %0d dat4 %h expected master %0d dat4 %h", c, mst, mst ? io_m1_dat4 : io_m0_dat4, e.mst, e.dat4);
          else n_pass++;
        end
      end
      next_cycle();
    end
    io_m0_sel = 1'b0; io_m1_sel = 1'b0; io_m1_we = 1'b0;
    n_total++; if (acks0 != 2 || acks1 != 2) $display("FAIL rr_ack_counts: got m0=%0d m1=%0d expected 2 2", acks0, acks1); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL rr_sb_leftover: got %0d entries expected 0", sb_q.size()); else n_pass++;
    sb_q.delete();
    next_cycle();
  endtask

  task automatic test_m1_read();
    exp_t e;
    slv_ack = 1'b0; slv_fixed_en = 1'b1; slv_fixed = 32'hDEAD_BEEF;
    io_m1_sel = 1'b1; io_m1_we = 1'b0; io_m1_addr = 32'h0000_0300;
    sb_q.push_back('{mst: 1'b1, dat4: 32'hDEAD_BEEF});
    for (int c = 0; c < 5; c++) begin
      slv_ack = (c == 4);
      @(negedge clk);
      n_total++; if (io_m0_dat4 !== '0) $display("FAIL rd_m0_dat4_c%0d: got %h expected 0", c, io_m0_dat4); else n_pass++;
      n_total++; if (io_m1_ack !== (c == 4)) $display("FAIL rd_m1_ack_c%0d: got %b expected %b", c, io_m1_ack, (c == 4)); else n_pass++;
      if (c == 4) begin
        n_total++;
        if (sb_q.size() == 0) $display("FAIL rd_sb_empty: got ack expected none");
        else begin
          e = sb_q.pop_front();
          if (e.mst !== 1'b1 || io_m1_dat4 !== e.dat4) $display("FAIL rd_sb: got m1 dat4 %h expected master %0d dat4 %h", io_m1_dat4, e.mst, e.dat4); else n_pass++;
        end
      end
      next_cycle();
    end
    io_m1_sel = 1'b0; slv_ack = 1'b0; slv_fixed_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_abort();
    exp_t e;
    slv_ack = 1'b0;
    io_m0_sel = 1'b1; io_m0_addr = 32'h0000_0400;
    io_m1_sel = 1'b1; io_m1_addr = 32'h0000_0500;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_total++; if (io_grant !== 2'b01 || io_bus_addr !== 32'h0000_0400) $display("FAIL ab_grant0: got %b addr %h expected 01 00000400", io_grant, io_bus_addr); else n_pass++;
    next_cycle();
    io_m0_sel = 1'b0;
    @(negedge clk);
    n_total++; if (io_bus_sel !== 1'b0 || io_m0_ack !== 1'b0) $display("FAIL ab_drop_same_cycle: got sel=%b ack=%b expected 0 0", io_bus_sel, io_m0_ack); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (io_grant !== 2'b00 || io_m0_ack !== 1'b0) $display("FAIL ab_idle: got grant=%b ack=%b expected 00 0", io_grant, io_m0_ack); else n_pass++;
    next_cycle();
    slv_ack = 1'b1;
    sb_q.push_back('{mst: 1'b1, dat4: 32'h0000_0500 ^ SLV_K});
    @(negedge clk);
    n_total++; if (io_grant !== 2'b10 || io_bus_addr !== 32'h0000_0500) $display("FAIL ab_pending_m1: got %b addr %h expected 10 00000500", io_grant, io_bus_addr); else n_pass++;
    n_total++;
    if (io_m1_ack !== 1'b1) $display("FAIL ab_m1_ack: got %b expected 1", io_m1_ack);
    else if (sb_q.size() == 0) $display("FAIL ab_sb_empty: got ack expected none");
    else begin
      e = sb_q.pop_front();
      if (e.mst !== 1'b1 || io_m1_dat4 !== e.dat4) $display("FAIL ab_sb: got m1 dat4 %h expected %h", io_m1_dat4, e.dat4); else n_pass++;
    end
    next_cycle();
    io_m1_sel = 1'b0; slv_ack = 1'b0;
    sb_q.delete();
    next_cycle();
  endtask

  task automatic test_hold_timeout();
    int bad;
    slv_ack = 1'b0;
    io_m0_sel = 1'b1; io_m0_addr = 32'h0000_0600;
    next_cycle();
`ifdef IO_ARB_TIMEOUT_EN
    for (int n = 1; n <= TMO + 1; n++) begin
      @(negedge clk);
      n_total++;
      if (io_m0_ack !== (n == TMO + 1) || io_m0_err !== (n == TMO + 1) || io_bus_sel !== (n != TMO + 1))
        $display("FAIL to_cycle%0d: got ack=%b err=%b sel=%b expected %b %b %b", n, io_m0_ack, io_m0_err, io_bus_sel, (n == TMO + 1), (n == TMO + 1), (n != TMO + 1));
      else n_pass++;
      next_cycle();
    end
    io_m0_sel = 1'b0;
    @(negedge clk);
    n_total++; if (io_grant !== 2'b00 || io_m0_err !== 1'b0) $display("FAIL to_back_idle: got grant=%b err=%b expected 00 0", io_grant, io_m0_err); else n_pass++;
    next_cycle();
`else
    bad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (io_m0_err !== 1'b0 || io_m0_ack !== 1'b0 || io_grant !== 2'b01) bad++;
      next_cycle();
    end
    n_total++; if (bad != 0) $display("FAIL hold_100_cycles: got %0d bad cycles expected 0", bad); else n_pass++;
    @(negedge clk);
    n_total++; if (io_grant !== 2'b01 || io_m0_err !== 1'b0) $display("FAIL hold_still_granted: got grant=%b err=%b expected 01 0", io_grant, io_m0_err); else n_pass++;
    io_m0_sel = 1'b0;
    next_cycle();
    next_cycle();
`endif
  endtask

  task automatic test_reset_mid();
    slv_ack = 1'b0;
    io_m1_sel = 1'b1; io_m1_we = 1'b1; io_m1_addr = 32'h0000_0700; io_m1_dat2 = 32'h0BAD_F00D;
    next_cycle();
    @(negedge clk);
    n_total++; if (io_grant !== 2'b10) $display("FAIL rm_granted: got %b expected 10", io_grant); else n_pass++;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (all_out !== '0) $display("FAIL rm_outputs_zero: got %h expected 0", all_out); else n_pass++;
    next_cycle();
    reset = 1'b0; io_m1_sel = 1'b0;
    @(negedge clk);
    n_total++; if (io_grant !== 2'b00 || io_m1_ack !== 1'b0 || io_m1_err !== 1'b0) $display("FAIL rm_idle_after: got grant=%b ack=%b err=%b expected 00 0 0", io_grant, io_m1_ack, io_m1_err); else n_pass++;
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    slv_ack = 1'b0; slv_fixed_en = 1'b0; slv_fixed = '0;
    io_m0_sel = 1'b0; io_m0_we = 1'b0; io_m0_addr = '0; io_m0_dat2 = '0;
    io_m1_sel = 1'b0; io_m1_we = 1'b0; io_m1_addr = '0; io_m1_dat2 = '0;
    test_reset();
    test_m0_write();
    test_round_robin();
    test_m1_read();
    test_abort();
    test_hold_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000ns");
    $fatal(1, "bench stalled");
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the 32-bit peripheral I/O bus (sel/we/addr/dat2 write data/dat4 read data/ack).
- Shares one slave port, e.g. the seven-segment display device, between the CPU master (m0) and a debug/DMA master (m1).
- Round-robin on contention.
- A grant is held until the slave acks or the master drops sel.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles to wait for slave ack before forced termination (used only with the optional feature)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- io_m0_sel  input  1  master 0 request; held until ack
- io_m0_we  input  1  master 0 write enable
- io_m0_addr  input  ADDR_W  master 0 address
- io_m0_dat2  input  DATA_W  master 0 write data
- io_m0_dat4  output  DATA_W  master 0 read data
- io_m0_ack  output  1  master 0 transfer complete
- io_m0_err  output  1  master 0 transfer terminated by timeout
- io_m1_sel, io_m1_we, io_m1_addr, io_m1_dat2, io_m1_dat4, io_m1_ack, io_m1_err: same as the m0 group, for master 1
- io_bus_sel  output  1  slave select
- io_bus_we  output  1  slave write enable
- io_bus_addr  output  ADDR_W  slave address
- io_bus_dat2  output  DATA_W  slave write data
- io_bus_dat4  input  DATA_W  slave read data
- io_bus_ack  input  1  slave ack
- io_grant  output  2  one-hot current grant, for debug; 2'b00 when idle

Behaviour:
States:
- IDLE, GNT0, GNT1; the state is registered.
- A registered last_grant bit records the winner of the most recent arbitration (0 = m0, 1 = m1).

Reset (synchronous):
- state = IDLE, last_grant = 1, so m0 wins the first tie.
- Timeout counter = 0.
- All outputs are 0 during reset and in IDLE: io_bus_sel, io_bus_we, io_bus_addr, io_bus_dat2, both acks, both errs, both dat4, io_grant.

IDLE:
- Only m0_sel: next state GNT0, last_grant <= 0.
- Only m1_sel: next state GNT1, last_grant <= 1.
- Both: grant the master not equal to last_grant, i.e. GNT0 if last_grant = 1, else GNT1; last_grant is updated to the winner.
- Neither: stay in IDLE.
- Arbitration latency is 1 cycle: the slave sees io_bus_sel on the cycle after the request is first seen in IDLE.

GNTx:
- Bus signals are combinationally muxed from master x: io_bus_sel = io_mx_sel, plus we, addr and dat2.
- io_mx_ack = io_bus_ack and io_mx_dat4 = io_bus_dat4, combinationally.
- The non-granted master sees ack = 0, err = 0, dat4 = 0.
- io_grant has bit x set.

Leaving GNTx:
- io_bus_ack = 1: next state IDLE.
- Master x drops sel before ack (abort): next state IDLE; no ack is issued, and the slave sees sel low that same cycle.
- Ack and sel-drop in the same cycle: the ack wins and is reported to master x.

Throughput and fairness:
- An always-ack slave completes a transfer in 1 granted cycle.
- Minimum spacing is 2 cycles per transfer (IDLE + GNT), so with both masters requesting continuously the grants alternate m0, m1, m0, ...
- A request from the non-granted master that arrives during GNTx is not lost. It is held by that master and arbitrated in the next IDLE.

Reset mid-transfer: state returns to IDLE immediately on the reset cycle; no ack or err is generated.

Optional Feature:
- Macro: IO_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GNTx and increments each GNTx cycle without ack.
  - When the counter equals TIMEOUT with no ack, the block asserts io_mx_ack = 1 and io_mx_err = 1 for that one cycle, forces io_bus_sel = 0, and returns to IDLE.
  - The counter width is clog2(TIMEOUT+1).
  - An ack arriving on the terminal cycle takes priority: normal ack, err = 0.
- Not defined:
  - No counter; a grant can be held indefinitely.
  - io_m0_err and io_m1_err are tied to 0.

Test Plan:
- Reset held for 2 cycles with both sels high -> all outputs 0 and io_grant = 00; first cycle after reset deasserts: grant goes to m0 on the next edge, io_grant = 01.
- m0 write (addr 0x0000_FF00, dat2 0x1234_5678, we = 1), slave ack tied 1 -> io_bus_sel high 1 cycle after request with dat2 = 0x1234_5678; io_m0_ack = 1 in that cycle; io_m1_ack = 0.
- Both masters request continuously for 8 cycles, slave ack tied 1 -> grants alternate m0, m1, m0, m1 (4 transfers); each master gets exactly 2 acks.
- m1 read, slave acks after 3 wait cycles with io_bus_dat4 = 0xDEAD_BEEF -> io_m1_dat4 = 0xDEAD_BEEF and io_m1_ack in the ack cycle; io_m0_dat4 stays 0 throughout.
- m0 drops sel in the 2nd GNT0 cycle without a slave ack -> io_bus_sel low the same cycle, state IDLE next cycle, no ack; a pending m1 request is granted next.
- With IO_ARB_TIMEOUT_EN and TIMEOUT = 15, slave ack stuck at 0 -> io_m0_ack = 1 and io_m0_err = 1 on the 16th GNT0 cycle, then IDLE. Without the macro, the grant is still held after 100 cycles and err stays 0.
